// File: rtl/ifetch_pkg.sv
// Shared widths, reset PC and fetch-buffer entry type for the instruction fetch request stage.
package ifetch_pkg;

  localparam int unsigned PcWidth     = 32;
  localparam int unsigned TagWidth    = 20;
  localparam int unsigned IndexWidth  = 7;
  localparam int unsigned OffsetWidth = 5;

  localparam logic [PcWidth-1:0] ResetPcDefault = 32'hBFC0_0000;

  typedef struct packed {
    logic [PcWidth-1:0] pc;
    logic [31:0]        inst;
    logic               adel;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Instruction buffer between Icache returns and decode; flush empties it and overrides push/pop.
module inst_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            push,
  input  fetch_entry_t    push_data,
  input  logic            pop,
  output fetch_entry_t    head,
  output logic [CntW-1:0] count,
  output logic            empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic            full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Zero the head when empty so decode never sees stale entries.
  assign head  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ifetch_req.sv
// Fetch request generator: issues Icache reads under a credit rule, pairs returns with their PCs,
// discards returns made stale by a redirect, and raises fetch address errors.
module ifetch_req
  import ifetch_pkg::*;
#(
  parameter logic [PcWidth-1:0] RESET_PC   = ResetPcDefault,
  parameter int unsigned        FIFO_DEPTH = 4,
  parameter int unsigned        MAX_OUTST  = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   redirect_valid,
  input  logic [PcWidth-1:0]     redirect_pc,
  output logic                   inst_valid,
  output logic                   inst_op,
  output logic [IndexWidth-1:0]  inst_index,
  output logic [TagWidth-1:0]    inst_tag,
  output logic [OffsetWidth-1:0] inst_offset,
  output logic [3:0]             inst_wstrb,
  output logic [31:0]            inst_wdata,
  input  logic                   inst_addr_ok,
  input  logic                   inst_data_ok,
  input  logic [31:0]            inst_rdata,
  output logic                   fs_valid,
  output logic [PcWidth-1:0]     fs_pc,
  output logic [31:0]            fs_inst,
  output logic                   fs_adel,
  input  logic                   ds_allowin
);

  localparam int unsigned OutstW = $clog2(MAX_OUTST + 1);
  localparam int unsigned PqPtrW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);

  logic               run_q;
  logic [PcWidth-1:0] pc_q, pc_d;
  logic [OutstW-1:0]  outst_q, outst_d;
  logic [OutstW-1:0]  discard_q, discard_d;
  logic               stop_q, stop_d;
  logic [PcWidth-1:0] pq_q [MAX_OUTST];
  logic [PqPtrW-1:0]  pq_rd_q, pq_rd_d, pq_wr_q, pq_wr_d;

  logic [CntW-1:0]    fifo_count;
  logic               fifo_empty, fifo_push, fifo_pop;
  fetch_entry_t       push_entry, head_entry;

  logic [31:0]        credit_used;
  logic               pc_aligned, fetch_en, req_acc, adel_push;

  function automatic logic [PqPtrW-1:0] pq_next(input logic [PqPtrW-1:0] p);
    return (32'(p) == MAX_OUTST - 1) ? '0 : p + 1'b1;
  endfunction

  // In-flight requests plus buffered entries may never exceed the buffer, so returns always fit.
  assign credit_used = 32'(outst_q) + 32'(fifo_count);
  assign pc_aligned  = (pc_q[1:0] == 2'b00);
  assign fetch_en    = run_q && !redirect_valid && !stop_q;
  assign inst_valid  = fetch_en && pc_aligned && (32'(outst_q) < MAX_OUTST) &&
                       (credit_used < FIFO_DEPTH);
  assign req_acc     = inst_valid && inst_addr_ok;
  assign adel_push   = fetch_en && !pc_aligned && (outst_q == '0) &&
                       (32'(fifo_count) < FIFO_DEPTH);

  assign inst_op     = 1'b0;
  assign inst_wstrb  = 4'h0;
  assign inst_wdata  = 32'h0;
  assign inst_offset = pc_q[OffsetWidth-1:0];
  assign inst_index  = pc_q[OffsetWidth +: IndexWidth];
  assign inst_tag    = pc_q[PcWidth-1 -: TagWidth];

  always_comb begin
    pc_d       = pc_q;
    stop_d     = stop_q;
    discard_d  = discard_q;
    pq_rd_d    = pq_rd_q;
    pq_wr_d    = pq_wr_q;
    fifo_push  = 1'b0;
    push_entry = '0;

    if (req_acc) begin
      pc_d    = pc_q + 32'd4;
      pq_wr_d = pq_next(pq_wr_q);
    end

    if (inst_data_ok) begin
      pq_rd_d = pq_next(pq_rd_q);
      if (discard_q != '0) begin
        discard_d = discard_q - 1'b1;
      end else begin
        fifo_push       = 1'b1;
        push_entry.pc   = pq_q[pq_rd_q];
        push_entry.inst = inst_rdata;
        push_entry.adel = 1'b0;
      end
    end else if (adel_push) begin
      fifo_push       = 1'b1;
      push_entry.pc   = pc_q;
      push_entry.inst = 32'h0;
      push_entry.adel = 1'b1;
      stop_d          = 1'b1;
    end

    outst_d = outst_q + OutstW'(req_acc) - OutstW'(inst_data_ok);

    // Every request still in flight after this cycle belongs to the old path.
    if (redirect_valid) begin
      pc_d      = redirect_pc;
      stop_d    = 1'b0;
      discard_d = outst_q - OutstW'(inst_data_ok);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_q     <= 1'b0;
      pc_q      <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
      stop_q    <= 1'b0;
      pq_rd_q   <= '0;
      pq_wr_q   <= '0;
    end else begin
      run_q     <= 1'b1;
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      stop_q    <= stop_d;
      pq_rd_q   <= pq_rd_d;
      pq_wr_q   <= pq_wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_acc) pq_q[pq_wr_q] <= pc_q;
  end

  assign fs_valid = !fifo_empty;
  assign fifo_pop = fs_valid && ds_allowin;
  assign fs_pc    = head_entry.pc;
  assign fs_inst  = head_entry.inst;
  assign fs_adel  = head_entry.adel;

  inst_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_inst_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head_entry),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assert property (@(posedge clk) disable iff (!resetn) inst_data_ok |-> (outst_q != '0));
  assert property (@(posedge clk) disable iff (!resetn) 32'(outst_q) <= MAX_OUTST);

endmodule

// File: doc/ifetch_req.md
IFETCH_REQ -- requirements
Module: ifetch_req

Interface
REQ-001 Parameters SHALL be: RESET_PC, default 32'hBFC0_0000, first fetch address; FIFO_DEPTH, default 4 (power of two, >=2), instruction buffer entries; MAX_OUTST, default 2, maximum outstanding cache requests.
REQ-002 Ports SHALL be (name direction width meaning):
clk in 1 sole clock, rising edge;
resetn in 1 asynchronous active-low reset;
redirect_valid in 1 branch/exception redirect strobe;
redirect_pc in 32 new fetch PC;
inst_valid out 1 Icache request valid;
inst_op out 1 constant 0 (read);
inst_index out 7 PC[11:5];
inst_tag out 20 PC[31:12];
inst_offset out 5 PC[4:0];
inst_wstrb out 4 constant 0;
inst_wdata out 32 constant 0;
inst_addr_ok in 1 Icache request accepted;
inst_data_ok in 1 Icache data return, in request order;
inst_rdata in 32 returned instruction;
fs_valid out 1 decode-side entry valid;
fs_pc out 32 entry PC;
fs_inst out 32 entry instruction;
fs_adel out 1 entry carries address-error (fetch) exception;
ds_allowin in 1 decode accepts entry.

Function
REQ-003 Request accepted SHALL mean inst_valid && inst_addr_ok in the same cycle; on acceptance fetch PC <= PC+4 (32-bit wrap) and outst increments.
REQ-004 inst_valid SHALL be 1 only when: not redirect cycle, PC[1:0]==0, no stop flag, outst < MAX_OUTST, and outst + fifo_count < FIFO_DEPTH (credit rule; buffer never overflows).
REQ-005 inst_valid SHALL hold with stable index/tag/offset until accepted or redirect; no combinational path from inst_addr_ok to inst_valid.
REQ-006 A 2-entry in-order PC queue SHALL record each accepted PC; head pops on every inst_data_ok.
REQ-007 On inst_data_ok with discard_cnt==0: push {head PC, inst_rdata, adel=0} into buffer; with discard_cnt>0: drop, discard_cnt decrements.
REQ-008 On redirect_valid: PC <= redirect_pc, buffer emptied, stop cleared, discard_cnt <= outst minus 1 if inst_data_ok same cycle (plus accepted request that cycle, which is impossible since inst_valid=0).
REQ-009 Redirect while discard_cnt>0 SHALL set discard_cnt to total outstanding, never lose a pending discard.
REQ-010 PC[1:0]!=0 with no outstanding requests SHALL push one entry {PC, 32'h0, adel=1}, then set stop; no Icache request issued until redirect.
REQ-011 fs_valid = buffer non-empty; head pops when fs_valid && ds_allowin; simultaneous push and pop SHALL keep count unchanged.
REQ-012 Buffer empty with ds_allowin: fs_valid 0, no pop; fetch-to-fs_valid latency SHALL be 1 cycle after inst_data_ok (registered push).
REQ-013 outst SHALL never exceed MAX_OUTST nor underflow; inst_data_ok with outst==0 is illegal (assertion).

Reset
REQ-014 Asynchronous on resetn low: PC=RESET_PC, outst=0, discard_cnt=0, stop=0, buffer and PC queue empty.
REQ-015 Outputs during and immediately after reset: inst_valid=0 while resetn low, fs_valid=0, fs_pc/fs_inst=0, fs_adel=0; first request at RESET_PC the cycle after deassertion.
REQ-016 Reset mid-transaction SHALL abandon outstanding requests; Icache is reset in the same domain.

Structure
REQ-017 Package ifetch_pkg SHALL hold RESET_PC default, PC width 32, tag/index/offset widths 20/7/5 and the fetch-entry typedef {pc, inst, adel}.
REQ-018 Buffer SHALL be sub-module inst_fifo (parameterized depth, push/pop/count/flush); PC queue and counters in top.

Verification
REQ-019 Reset release, Icache addr_ok=1 every cycle, data_ok one cycle later -> requests at BFC00000, BFC00004, ...; fs_pc sequence identical, no gaps with ds_allowin=1.
REQ-020 ds_allowin=0 for 10 cycles -> at most FIFO_DEPTH-outst requests issued, buffer count reaches 4, no data lost; release drains in order.
REQ-021 Two outstanding (BFC00000, BFC00004), redirect to 80001000 before returns -> both returns dropped, next fs_pc=80001000.
REQ-022 Redirect in same cycle as data_ok for one of two outstanding -> discard_cnt=1, exactly one later return dropped.
REQ-023 Redirect to 80000002 -> no inst_valid, one entry fs_pc=80000002 fs_adel=1 fs_inst=0, then idle until next redirect.
REQ-024 Assert resetn low with one request outstanding -> all outputs to reset values immediately; restart at BFC00000.
